// File: rtl/req_gnt_pkg.sv
// rtl/req_gnt_pkg.sv - shared types and helpers for the req/gnt/busy responder
// Contents: state_e (responder FSM states), idx_width (owner/pointer width),
//           cnt_width (phase counter width), params_legal (parameter range check).
package req_gnt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    GRANT   = 3'd2,
    BUSY    = 3'd3,
    RECOVER = 3'd4
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The counter is reloaded with (length - 1) on phase entry, so it only
  // has to hold the largest phase length.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_legal(input int num_req, input int gnt_dly,
                                      input int busy_cycles, input int idle_cycles);
    return (num_req >= 2) && (num_req <= 16) &&
           (gnt_dly >= 1) && (gnt_dly <= 3) &&
           (busy_cycles >= 1) && (idle_cycles >= 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick
// Ports: req    - request vector
//        rr_ptr - index of the last winner; search starts one past it
//        winner - index of the chosen requester
//        valid  - at least one request is pending
module rr_arbiter
  import req_gnt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  logic [IW:0] sum;

  // Walk offsets from farthest to nearest so the nearest requester after
  // rr_ptr overwrites any earlier hit and ends up as the winner.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(off);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      if (req[sum[IW-1:0]]) begin
        winner = sum[IW-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_gnt_responder.sv
// rtl/req_gnt_responder.sv - grant-side responder for the req/gnt/busy handshake
// Ports: clk, rst (sync, active-high)
//        req          - per-requester request level
//        stall        - extends the busy phase once its counted cycles expire
//        gnt          - one-hot single-cycle grant pulse
//        busy         - resource occupied by owner
//        owner        - index of current or last granted requester
//        done         - high in the final busy cycle
//        protocol_err - sticky; owner still requesting at start of recovery
module req_gnt_responder
  import req_gnt_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GNT_DLY     = 1,
  parameter int BUSY_CYCLES = 1,
  parameter int IDLE_CYCLES = 1,
  localparam int IW = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               stall,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic [IW-1:0]      owner,
  output logic               done,
  output logic               protocol_err
);

  localparam int CW = cnt_width(GNT_DLY, BUSY_CYCLES, IDLE_CYCLES);

  if (!params_legal(NUM_REQ, GNT_DLY, BUSY_CYCLES, IDLE_CYCLES)) begin : g_param_err
    $error("req_gnt_responder: illegal parameter set");
  end

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic                 protocol_err_q, protocol_err_d;
  logic                 done_c;

  logic [IW-1:0]        arb_winner;
  logic                 arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // Each phase counter is loaded with (length - 1) on entry and the phase
  // ends on the edge where it reads zero.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    protocol_err_d = protocol_err_q;
    done_c         = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d = arb_winner;
          if (GNT_DLY > 1) begin
            state_d = WAIT;
            cnt_d   = CW'(GNT_DLY - 2);
          end else begin
            state_d  = GRANT;
            rr_ptr_d = arb_winner;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = GRANT;
          rr_ptr_d = owner_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GRANT: begin
        state_d = BUSY;
        cnt_d   = CW'(BUSY_CYCLES - 1);
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!stall) begin
          // The exit depends on stall in this very cycle, so done cannot be
          // known a cycle ahead; it is the one output that sees stall directly.
          done_c  = 1'b1;
          state_d = RECOVER;
          cnt_d   = CW'(IDLE_CYCLES - 1);
          if (req[owner_q]) protocol_err_d = 1'b1;
        end
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // gnt/busy are registered from the next state so they line up with state_q.
  always_comb begin
    gnt_d  = (state_d == GRANT) ? (NUM_REQ'(1) << owner_d) : '0;
    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      owner_q        <= '0;
      rr_ptr_q       <= IW'(NUM_REQ - 1);
      gnt_q          <= '0;
      busy_q         <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      gnt_q          <= gnt_d;
      busy_q         <= busy_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign gnt          = gnt_q;
  assign busy         = busy_q;
  assign owner        = owner_q;
  assign done         = done_c;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_req_gnt_responder.sv
// tb/tb_req_gnt_responder.sv - directed self-checking bench for req_gnt_responder
module tb_req_gnt_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [3:0] req_a = '0, req_b = '0, req_c = '0;
  logic       stall_a = 1'b0, stall_b = 1'b0, stall_c = 1'b0;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic       busy_a, busy_b, busy_c;
  logic [1:0] owner_a, owner_b, owner_c;
  logic       done_a, done_b, done_c;
  logic       err_a, err_b, err_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  req_gnt_responder u_def (
    .clk (clk), .rst (rst), .req (req_a), .stall (stall_a),
    .gnt (gnt_a), .busy (busy_a), .owner (owner_a), .done (done_a), .protocol_err (err_a)
  );

  req_gnt_responder #(.GNT_DLY(3)) u_dly (
    .clk (clk), .rst (rst), .req (req_b), .stall (stall_b),
    .gnt (gnt_b), .busy (busy_b), .owner (owner_b), .done (done_b), .protocol_err (err_b)
  );

  req_gnt_responder #(.BUSY_CYCLES(2), .IDLE_CYCLES(2)) u_stl (
    .clk (clk), .rst (rst), .req (req_c), .stall (stall_c),
    .gnt (gnt_c), .busy (busy_c), .owner (owner_c), .done (done_c), .protocol_err (err_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_all();
    req_a = '0; req_b = '0; req_c = '0;
    stall_a = 1'b0; stall_b = 1'b0; stall_c = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] exp_gnt;
  int         stall_tbl [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  int         busy_tbl  [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
  int         done_tbl  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    // reset state
    reset_all();
    check_eq("rst_gnt",   32'(gnt_a), 0);
    check_eq("rst_busy",  32'(busy_a), 0);
    check_eq("rst_owner", 32'(owner_a), 0);
    check_eq("rst_done",  32'(done_a), 0);
    check_eq("rst_err",   32'(err_a), 0);
    check_eq("rst_err_b", 32'(err_b), 0);
    check_eq("rst_busy_c", 32'(busy_c), 0);

    // single transaction, defaults
    req_a = 4'b0001;
    tick();
    check_eq("t1_gnt",   32'(gnt_a), 32'h1);
    check_eq("t1_busy0", 32'(busy_a), 0);
    check_eq("t1_owner", 32'(owner_a), 0);
    req_a = '0;
    tick();
    check_eq("t1_busy",  32'(busy_a), 1);
    check_eq("t1_gnt0",  32'(gnt_a), 0);
    check_eq("t1_done",  32'(done_a), 1);
    tick();
    check_eq("t1_rec_busy", 32'(busy_a), 0);
    check_eq("t1_rec_gnt",  32'(gnt_a), 0);
    check_eq("t1_rec_done", 32'(done_a), 0);
    check_eq("t1_err",      32'(err_a), 0);

    // GNT_DLY=3, req[2] held into recovery
    reset_all();
    req_b = 4'b0100;
    tick();
    check_eq("t2_wait1_gnt", 32'(gnt_b), 0);
    tick();
    check_eq("t2_wait2_gnt", 32'(gnt_b), 0);
    tick();
    check_eq("t2_gnt",   32'(gnt_b), 32'h4);
    check_eq("t2_owner", 32'(owner_b), 2);
    tick();
    check_eq("t2_busy",  32'(busy_b), 1);
    check_eq("t2_gnt0",  32'(gnt_b), 0);
    check_eq("t2_err0",  32'(err_b), 0);
    tick();
    check_eq("t2_rec_busy", 32'(busy_b), 0);
    check_eq("t2_err1",     32'(err_b), 1);
    req_b = '0;
    tick();
    tick();
    tick();
    check_eq("t2_err_sticky", 32'(err_b), 1);
    check_eq("t2_gnt_end",    32'(gnt_b), 0);

    // all requesting: round-robin 0,1,2,3,0
    reset_all();
    req_a = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_gnt = 4'b0001 << (t % 4);
      tick();
      check_eq("t3_gnt",    32'(gnt_a), 32'(exp_gnt));
      check_eq("t3_owner",  32'(owner_a), 32'(t % 4));
      check_eq("t3_busy0",  32'(busy_a), 0);
      tick();
      check_eq("t3_busy",   32'(busy_a), 1);
      check_eq("t3_bgnt0",  32'(gnt_a), 0);
      tick();
      check_eq("t3_rgnt0",  32'(gnt_a), 0);
      check_eq("t3_rbusy0", 32'(busy_a), 0);
      if (t == 0) check_eq("t3_err", 32'(err_a), 1);
      tick();
      check_eq("t3_ignt0",  32'(gnt_a), 0);
    end
    req_a = '0;

    // BUSY_CYCLES=2, IDLE_CYCLES=2, stall extends busy to 5 cycles
    reset_all();
    req_c = 4'b0001;
    tick();
    check_eq("t4_gnt", 32'(gnt_c), 32'h1);
    req_c = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      stall_c = stall_tbl[c][0];
      #1;
      check_eq("t4_busy", 32'(busy_c), 32'(busy_tbl[c]));
      check_eq("t4_done", 32'(done_c), 32'(done_tbl[c]));
      if (c > 0) check_eq("t4_gnt0", 32'(gnt_c), 0);
    end
    tick();
    req_c = 4'b0010;
    tick();
    check_eq("t4_regrant", 32'(gnt_c), 32'h2);
    req_c = '0;

    // reset in the first busy cycle
    reset_all();
    req_a = 4'b0010;
    tick();
    check_eq("t5_gnt", 32'(gnt_a), 32'h2);
    tick();
    check_eq("t5_busy", 32'(busy_a), 1);
    req_a = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_rst_busy",  32'(busy_a), 0);
    check_eq("t5_rst_gnt",   32'(gnt_a), 0);
    check_eq("t5_rst_owner", 32'(owner_a), 0);
    tick();
    check_eq("t5_quiet_busy", 32'(busy_a), 0);
    check_eq("t5_quiet_gnt",  32'(gnt_a), 0);
    req_a = 4'b1000;
    tick();
    check_eq("t5_gnt3",   32'(gnt_a), 32'h8);
    check_eq("t5_owner3", 32'(owner_a), 3);
    req_a = '0;
    tick();
    tick();

    // request pulsed only while busy is ignored
    reset_all();
    req_a = 4'b0001;
    tick();
    req_a = '0;
    tick();
    check_eq("t6_busy", 32'(busy_a), 1);
    req_a = 4'b0010;
    tick();
    req_a = '0;
    check_eq("t6_rec_gnt", 32'(gnt_a), 0);
    check_eq("t6_err",     32'(err_a), 0);
    tick();
    check_eq("t6_idle_gnt", 32'(gnt_a), 0);
    tick();
    check_eq("t6_idle2_gnt",  32'(gnt_a), 0);
    check_eq("t6_idle2_busy", 32'(busy_a), 0);
    req_a = 4'b0010;
    tick();
    check_eq("t6_gnt1",   32'(gnt_a), 32'h2);
    check_eq("t6_owner1", 32'(owner_a), 1);
    req_a = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
